// File: rtl/serial_add_pkg.sv
// Shared constants and state encodings for the bit-serial add/subtract controller.
//   DEF_WIDTH / DEF_CNT_W : default operand width and bit-counter width
//   state_t               : controller state encoding (2'd3 is illegal, recovers to IDLE)
package serial_add_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Single 1-bit full adder cell, shared over time by the serial controller.
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract controller: one full-adder cell, one bit per
// clock, LSB first.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   sub         : 0 = a+b, 1 = a-b (two's complement)
//   a, b        : operands, captured when start is accepted
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse, high in DONE
//   sum         : result, held until the next done
//   cout        : final carry (subtract: 1 = no borrow)
//   ovf         : signed overflow
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_r_sh;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_s;
  logic               w_co;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;

  serial_fa_cell u_cell (
    .x   (r_a_sh[0]),
    .y   (r_b_sh[0]),
    .cin (r_c),
    .s   (w_s),
    .co  (w_co)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  // Result shifter with this cycle's sum bit entering at the MSB; on the last
  // bit this is the complete result.
  assign w_res  = {w_s, r_r_sh};

  // Controller: capture, bit-serial sequencing and registered outputs.
  // The result is latched on the final RUN edge so sum/cout/ovf appear in the
  // same cycle as done; r_c on that edge is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_r_sh  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            r_c     <= sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_r_sh <= w_res[WIDTH-1:1];
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_c    <= w_co;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            sum     <= w_res;
            cout    <= w_co;
            ovf     <= r_c ^ w_co;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
